// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// DMEM_BASE_ADDR sets the RAM window base address.
package dmem_resp_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int MEM_MASK_WIDTH = 4;

    localparam logic [ISA_WIDTH-1:0] DMEM_BASE_ADDR = 32'h8000_0000;

    localparam int DMEM_LAT_WIDTH = 4;
    localparam int DMEM_LAT_MAX   = 15;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Byte lanes touched by a low-aligned mask placed at a byte offset;
    // bits [7:4] are lanes that fall off the end of the word.
    function automatic logic [7:0] shifted_lanes(input logic [MEM_MASK_WIDTH-1:0] mask,
                                                 input logic [1:0] sh);
        shifted_lanes = {4'b0000, mask} << sh;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_rd_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-lane writes and registered read of the addressed word
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: request FSM, fixed latency, byte-masked stores,
// lane shifting of loads. Define DMEM_BOUND_CHECK_EN to enable illegal-access
// detection; otherwise indices wrap, spilling lanes truncate and write wins.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ISA_WIDTH-1:0]      mem_addr,
    input  logic [ISA_WIDTH-1:0]      mem_w,
    input  logic [MEM_MASK_WIDTH-1:0] mem_mask,
    input  logic                      mem_r_en,
    input  logic                      mem_w_en,
    output logic                      req_ready,
    output logic [ISA_WIDTH-1:0]      mem_r,
    output logic                      resp_valid,
    output logic                      err,
    output dmem_state_e               o_dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [DMEM_LAT_WIDTH-1:0] LAT_INIT =
        (LATENCY > 1) ? DMEM_LAT_WIDTH'(LATENCY - 2) : '0;

    // Handshake: a request is taken on any rising edge where req_ready and
    // (mem_r_en | mem_w_en) are both high; the requester holds its signals
    // until then. resp_valid is a single-cycle pulse with no backpressure.

    dmem_state_e               r_state, w_state_n;
    logic [DMEM_LAT_WIDTH-1:0] r_cnt, w_cnt_n;
    logic                      r_live;

    logic [AW-1:0] r_idx;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [1:0]    r_sh;
    logic          r_is_wr, r_is_rd, r_bad;

    logic          r_rsp_rd, r_rsp_bad;
    logic [1:0]    r_rsp_sh;

    logic          w_accept, w_access;
    logic [31:0]   w_off, w_wdata, w_rdata;
    logic [7:0]    w_lanes8;
    logic [AW-1:0] w_idx;
    logic          w_is_wr, w_is_rd, w_bad;

    logic [AW-1:0] w_a_idx;
    logic [3:0]    w_a_be;
    logic [31:0]   w_a_wdata;
    logic [1:0]    w_a_sh;
    logic          w_a_wr, w_a_rd, w_a_bad;

    assign w_accept = req_ready & (mem_r_en | mem_w_en);
    assign w_off    = mem_addr - DMEM_BASE_ADDR;
    assign w_lanes8 = shifted_lanes(mem_mask, mem_addr[1:0]);
    assign w_idx    = w_off[AW+1:2];
    assign w_wdata  = mem_w << {mem_addr[1:0], 3'b000};

`ifdef DMEM_BOUND_CHECK_EN
    assign w_bad   = (mem_r_en & mem_w_en) | (w_off >= BYTES)
                   | (mem_w_en & (|w_lanes8[7:4]));
    assign w_is_wr = mem_w_en & ~mem_r_en;
    assign w_is_rd = mem_r_en & ~mem_w_en;
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_off[31:AW+2], w_off[1:0], w_lanes8[7:4], BYTES[0]};
    assign w_bad   = 1'b0;
    assign w_is_wr = mem_w_en;
    assign w_is_rd = mem_r_en & ~mem_w_en;
`endif

    // Next-state and latency counter
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            DMEM_IDLE, DMEM_RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_n = DMEM_RESP;
                    end else begin
                        w_state_n = DMEM_WAIT;
                        w_cnt_n   = LAT_INIT;
                    end
                end else begin
                    w_state_n = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_n = DMEM_RESP;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: w_state_n = DMEM_IDLE;
        endcase
    end

    // RAM is touched on the edge entering RESP; a same-edge accept can only
    // lead there at single-cycle latency, so it selects the live request.
    assign w_access  = rst & (w_state_n == DMEM_RESP);
    assign w_a_idx   = w_accept ? w_idx          : r_idx;
    assign w_a_be    = w_accept ? w_lanes8[3:0]  : r_be;
    assign w_a_wdata = w_accept ? w_wdata        : r_wdata;
    assign w_a_sh    = w_accept ? mem_addr[1:0]  : r_sh;
    assign w_a_wr    = w_accept ? w_is_wr        : r_is_wr;
    assign w_a_rd    = w_accept ? w_is_rd        : r_is_rd;
    assign w_a_bad   = w_accept ? w_bad          : r_bad;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .i_rd_en(w_access & w_a_rd & ~w_a_bad),
        .i_be   ((w_access & w_a_wr & ~w_a_bad) ? w_a_be : 4'b0000),
        .i_idx  (w_a_idx),
        .i_wdata(w_a_wdata),
        .o_rdata(w_rdata)
    );

    // State, counter and response-qualifier registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= DMEM_IDLE;
            r_cnt     <= '0;
            r_live    <= 1'b0;
            r_rsp_rd  <= 1'b0;
            r_rsp_bad <= 1'b0;
            r_rsp_sh  <= 2'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_live  <= 1'b1;
            if (w_access) begin
                r_rsp_rd  <= w_a_rd;
                r_rsp_bad <= w_a_bad;
                r_rsp_sh  <= w_a_sh;
            end
        end
    end

    // Capture the accepted request for multi-cycle latencies
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_is_wr <= 1'b0;
            r_is_rd <= 1'b0;
            r_bad   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_idx;
            r_be    <= w_lanes8[3:0];
            r_wdata <= w_wdata;
            r_sh    <= mem_addr[1:0];
            r_is_wr <= w_is_wr;
            r_is_rd <= w_is_rd;
            r_bad   <= w_bad;
        end
    end

    assign req_ready   = r_live & (r_state != DMEM_WAIT);
    assign resp_valid  = (r_state == DMEM_RESP);
    assign err         = resp_valid & r_rsp_bad;
    assign mem_r       = (resp_valid & r_rsp_rd & ~r_rsp_bad)
                       ? (w_rdata >> {r_rsp_sh, 3'b000}) : '0;
    assign o_dbg_state = r_state;

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder that services the load/store requests driven by the execute-stage memory port (`mem_addr`, `mem_w`, `mem_mask`, `mem_r_en`, `mem_w_en`) and returns `mem_r`. It holds a local word-organised data RAM mapped at `` `BASE_ADDR ``, models a fixed access latency, commits byte-masked writes, and flags illegal accesses. It sits between the execute stage and the data RAM model, replacing the zero-latency DPI memory.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: RAM size in `` `ISA_WIDTH ``-bit words (4 KiB).
- `LATENCY`, default 1: cycles from request accept to response; legal range 1–15.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-low reset.
- `mem_addr` in `` `ISA_WIDTH ``: byte address.
- `mem_w` in `` `ISA_WIDTH ``: store data, low-aligned (byte in [7:0], half in [15:0]).
- `mem_mask` in `` `MEM_MASK_WIDTH ``: low-aligned byte mask (0001 / 0011 / 1111); ignored for reads.
- `mem_r_en` in 1: read request.
- `mem_w_en` in 1: write request.
- `req_ready` out 1: request accepted this cycle when high and `mem_r_en|mem_w_en`.
- `mem_r` out `` `ISA_WIDTH ``: read data, word right-shifted by `addr[1:0]*8`.
- `resp_valid` out 1: one-cycle response pulse; no backpressure.
- `err` out 1: qualifies `resp_valid`; access was illegal.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On accept, latch addr, data, mask, kind. Go to RESP if `LATENCY`==1, else WAIT with counter=`LATENCY`-2.
- WAIT: `req_ready`=0; decrement; at 0 go to RESP.
- RESP: `resp_valid`=1, `req_ready`=1. A new accept here re-enters WAIT/RESP as from IDLE; otherwise go to IDLE.
- RAM access happens on the edge entering RESP. Write: word `offset[..:2]` lanes `mask<<addr[1:0]` updated. Read: `mem_r` registered.
- offset = `mem_addr` − `` `BASE_ADDR ``.
- Error cases, each giving `err`=1, no write, and `mem_r`=0:
  - both enables high;
  - offset ≥ `DEPTH_WORDS`*4;
  - write with `mask<<addr[1:0]` spilling past bit 3.
- Requester must hold request signals stable until accepted.

## Timing
- Accept at cycle T gives `resp_valid` at T+`LATENCY`. At `LATENCY`=1, one request per cycle is sustained.
- Read-after-write to the same word, back-to-back: the read sees new data, because the write commits first.
- While `rst`=0: state IDLE, `req_ready`=0, `resp_valid`=0, `mem_r`=0, `err`=0, counter=0. The cycle after release, `req_ready`=1.
- Reset mid-operation drops any pending request. An uncommitted write is never performed. RAM contents are not reset.

## Configuration
- `` `DMEM_BOUND_CHECK_EN `` defined: the error checks above are active.
- Not defined:
  - `err` is tied 0.
  - Word index wraps modulo `DEPTH_WORDS`.
  - Spilling lanes are truncated.
  - When both enables are high, the write wins.

## Structure
- Add to `config.vh`: state encodings `DMEM_IDLE/WAIT/RESP`, `DMEM_LAT_WIDTH` (4), `DMEM_LAT_MAX`.
- Sub-module `dmem_array`: single-port RAM with byte-lane write enables and a registered read port. `dmem_resp` holds the FSM, latency counter, checks and lane shifting.

## Test plan
- `LATENCY`=1: write `mem_addr`=BASE+0x10, `mem_w`=0xDEADBEEF, mask 1111; then read BASE+0x10 → `resp_valid` at T+1 both times, `mem_r`=0xDEADBEEF, `err`=0.
- sb 0xAB to BASE+0x13, then read BASE+0x10 → `mem_r`=0xABADBEEF. Read BASE+0x13 → `mem_r`[7:0]=0xAB.
- `LATENCY`=4: read accepted at cycle 10 → `req_ready`=0 for cycles 11–13, `resp_valid` only at cycle 14.
- With `DMEM_BOUND_CHECK_EN`:
  - read BASE+0x1000 → `err`=1, `mem_r`=0;
  - sh to BASE+0x03 → `err`=1, word unchanged;
  - both enables → `err`=1.
- `LATENCY`=3: assert `rst`=0 one cycle after a write is accepted → no `resp_valid`, target word unchanged, `req_ready`=1 the cycle after release.
- `LATENCY`=1, 8 back-to-back alternating writes and reads → 8 consecutive `resp_valid` pulses with correct data.
